// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg: shared KGP-RISC widths, reset vector and fetch FSM encoding.
package kgp_risc_pkg;
    localparam int PC_W = 32;
    localparam int INSTR_W = 32;
    localparam int IMEM_AW = 10;
    localparam logic [31:0] BOOT_PC = 32'h0;
    localparam int PC_INC = 4;
    typedef enum logic {ST_RUN, ST_HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: 1-entry {instr,pc} hold register with load, unload and flush.
module fetch_skid_buffer #(
    parameter int PC_WIDTH = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   load,
    input  logic                   unload,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]    in_pc,
    output logic                   valid,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]    out_pc
);
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            out_instr <= in_instr;
            out_pc <= in_pc;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: KGP-RISC fetch stage driving a 1-cycle synchronous InstrMem
// and handing {instr, pc} to decode over valid/ready with redirect and halt.
module instr_fetch_unit
    import kgp_risc_pkg::*;
#(
    parameter int PC_WIDTH = PC_W,
    parameter int ADDR_WIDTH = IMEM_AW,
    parameter int INSTR_WIDTH = INSTR_W,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(BOOT_PC)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    input  logic                   halt,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   halted
);
    fetch_state_t state;
    logic [PC_WIDTH-1:0] fpc, req_pc, hold_pc, addr_pc, redir_pc;
    logic [INSTR_WIDTH-1:0] hold_instr;
    logic req_v, hold_v, run, redir, issue, load, flush;
    always_comb begin
        run = (state == ST_RUN) & ~halt;
        redir_pc = redirect_pc & ~PC_WIDTH'(3);
        redir = run & redirect_valid;
        addr_pc = rst ? RESET_PC : redir ? redir_pc : fpc;
        instr_valid = (hold_v | req_v) & ~redirect_valid;
        issue = run & (~instr_valid | instr_ready);
        instr = ~instr_valid ? '0 : hold_v ? hold_instr : imem_data;
        instr_pc = ~instr_valid ? '0 : hold_v ? hold_pc : req_pc;
        // capture the in-flight read only when decode refuses it and nothing squashes it
        load = req_v & ~hold_v & ~instr_ready & ~redirect_valid;
        flush = redirect_valid | ~run;
    end
    assign imem_addr = addr_pc[ADDR_WIDTH+1:2];
    assign halted = state == ST_HALTED;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            fpc <= RESET_PC;
            req_v <= 1'b0;
            req_pc <= '0;
        end else begin
            if (halt && state == ST_RUN) state <= ST_HALTED;
            req_v <= issue;
            if (issue) begin
                req_pc <= addr_pc;
                fpc <= addr_pc + PC_WIDTH'(PC_INC);
            end
        end
    end
    fetch_skid_buffer #(.PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) u_skid (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .load(load),
        .unload(instr_ready),
        .in_instr(imem_data),
        .in_pc(req_pc),
        .valid(hold_v),
        .out_instr(hold_instr),
        .out_pc(hold_pc)
    );
endmodule
